// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
// Blocks are eight 16-bit words, so a block base clears the low four address bits.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } arb_state_t;

  typedef enum logic {
    TGT_I,
    TGT_D
  } tgt_t;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam int          WORD_BYTES = 2;

endpackage

// File: rtl/fill_word_counter.sv
// Word index within a block fill: synchronous clear, count enable, and a flag
// raised while the count sits on the last word of the block.
module fill_word_counter #(
  parameter logic [2:0] LAST = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count,
  output logic       term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 3'd1;
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one multicycle main memory between the I- and D-cache: write-through
// stores and 8-word block fills, granted one at a time with stores first.
//
// state | meaning
// IDLE  | arbitrate pending requests (store > D miss > I miss)
// WRITE | store strobe in first cycle, then wait out the memory latency
// FILL  | issue 8 block reads, forward each returned word to the target cache
// DONE  | one cycle: pulse the target's fill_done
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_i_we,
  output logic              fill_d_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [15:0]       fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack
);

  localparam int                LAT_W     = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LAT - 1);
  localparam logic [2:0]        LAST_WORD = 3'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(BLOCK_MASK);

  arb_state_t        state;
  tgt_t              tgt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr;
  logic [LAT_W-1:0]  lat_cnt;

  logic [2:0] ic;
  logic [2:0] rc;
  logic       ic_term;
  logic       rc_term;
  logic       in_fill;
  logic       ic_en;
  logic       ret;

  assign in_fill = (state == FILL);
  assign ic_en   = in_fill && mem_en && !ic_term;
  assign ret     = in_fill && mem_rvalid;

  fill_word_counter #(.LAST(LAST_WORD)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .en    (ic_en),
    .count (ic),
    .term  (ic_term)
  );

  fill_word_counter #(.LAST(LAST_WORD)) u_return_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_fill),
    .en    (ret),
    .count (rc),
    .term  (rc_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tgt         <= TGT_I;
      base        <= '0;
      wr_addr     <= '0;
      lat_cnt     <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_ack    <= 1'b0;
    end else begin
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state     <= WRITE;
            tgt       <= TGT_D;
            wr_addr   <= d_wr_addr;
            mem_wdata <= d_wr_data;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            lat_cnt   <= LAT_LOAD;
            d_wr_ack  <= (MEM_LAT == 1);
          end else if (d_miss) begin
            state  <= FILL;
            tgt    <= TGT_D;
            base   <= d_miss_addr & BASE_MASK;
            mem_en <= 1'b1;
            mem_wr <= 1'b0;
          end else if (i_miss) begin
            state  <= FILL;
            tgt    <= TGT_I;
            base   <= i_miss_addr & BASE_MASK;
            mem_en <= 1'b1;
            mem_wr <= 1'b0;
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          // ack is registered, so it is raised one count before the timer expires
          if (lat_cnt == '0) begin
            state    <= IDLE;
            d_wr_ack <= 1'b0;
          end else begin
            lat_cnt  <= lat_cnt - LAT_W'(1);
            d_wr_ack <= (lat_cnt == LAT_W'(1));
          end
        end
        FILL: begin
          if (ic_term) begin
            mem_en <= 1'b0;
          end
          if (ret && rc_term) begin
            state <= DONE;
            if (tgt == TGT_I) begin
              i_fill_done <= 1'b1;
            end else begin
              d_fill_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    if (mem_en) begin
      mem_addr = mem_wr ? wr_addr : base + ADDR_W'(ic) * ADDR_W'(WORD_BYTES);
    end
  end

  // returned words pass straight through to the target cache's data array
  assign fill_i_we = ret && (tgt == TGT_I);
  assign fill_d_we = ret && (tgt == TGT_D);
  assign fill_addr = ret ? base + ADDR_W'(rc) * ADDR_W'(WORD_BYTES) : '0;
  assign fill_data = ret ? mem_rdata : '0;

  // caches may only release a request once its completion pulse is seen
  a_i_miss_held: assert property (@(posedge clk) disable iff (rst)
    $fell(i_miss) |-> (i_fill_done || $past(i_fill_done)));
  a_d_miss_held: assert property (@(posedge clk) disable iff (rst)
    $fell(d_miss) |-> (d_fill_done || $past(d_fill_done)));
  a_d_wr_held: assert property (@(posedge clk) disable iff (rst)
    $fell(d_wr_req) |-> (d_wr_ack || $past(d_wr_ack)));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised scoreboard bench for cache_mem_arbiter: a request-level model
// predicts every memory strobe and cache-side event with its cycle number.
module tb_cache_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  localparam int K_FILL_I = 0;
  localparam int K_FILL_D = 1;
  localparam int K_DONE_I = 2;
  localparam int K_DONE_D = 3;
  localparam int K_ACK    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        fill_i_we, fill_d_we;
  logic [15:0] fill_addr, fill_data;
  logic        i_fill_done, d_fill_done, d_wr_ack;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack)
  );

  // Main memory: fixed-latency read pipe over a word array.
  logic [15:0]        mem_words [32768];
  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pa [MEM_LAT];
  logic               inj = 1'b0;

  always @(posedge clk) begin
    pv    <= {pv[MEM_LAT-2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
    pa[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) pa[k] <= pa[k-1];
  end

  assign mem_rvalid = pv[MEM_LAT-1] | inj;
  assign mem_rdata  = pv[MEM_LAT-1] ? mem_words[pa[MEM_LAT-1][15:1]] : 16'hDEAD;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t cache_q[$];
  ev_t mem_q[$];
  int  n_vec = 0;
  int  n_mis = 0;
  bit  mon_on = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_ev(string nm, ev_t o, bit have, ev_t e);
    n_vec++;
    if (!have) begin
      n_mis++;
      $display("FAIL %s_unexpected: got kind %0d addr %h data %h cycle %0d, expected no event",
               nm, o.kind, o.addr, o.data, o.cyc);
    end else if (o.kind != e.kind || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
      n_mis++;
      $display("FAIL %s_event: got kind %0d addr %h data %h cycle %0d, expected kind %0d addr %h data %h cycle %0d",
               nm, o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
    end
  endtask

  // Monitor: pops one expectation per observed strobe on each side.
  initial begin : monitor
    ev_t o, e;
    int  nk;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        nk = int'(fill_i_we) + int'(fill_d_we) + int'(i_fill_done) + int'(d_fill_done) + int'(d_wr_ack);
        if (nk > 1) begin
          n_vec++;
          n_mis++;
          $display("FAIL cache_multi: %0d cache-side strobes in cycle %0d, expected at most 1", nk, cyc);
        end else if (nk == 1) begin
          o.kind = fill_i_we ? K_FILL_I : fill_d_we ? K_FILL_D :
                   i_fill_done ? K_DONE_I : d_fill_done ? K_DONE_D : K_ACK;
          o.addr = (fill_i_we || fill_d_we) ? fill_addr : 16'h0;
          o.data = (fill_i_we || fill_d_we) ? fill_data : 16'h0;
          o.cyc  = cyc;
          if (cache_q.size() > 0) begin
            e = cache_q.pop_front();
            cmp_ev("cache", o, 1'b1, e);
          end else begin
            cmp_ev("cache", o, 1'b0, o);
          end
        end
        if (mem_en !== 1'b0) begin
          o.kind = int'(mem_wr);
          o.addr = mem_addr;
          o.data = mem_wr ? mem_wdata : 16'h0;
          o.cyc  = cyc;
          if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            cmp_ev("mem", o, 1'b1, e);
          end else begin
            cmp_ev("mem", o, 1'b0, o);
          end
        end
      end
    end
  end

  // Reference model: requests raised together in cycle t are served store,
  // then D fill, then I fill, each with fixed spec timing.
  task automatic model_fill(int kf, int kd, logic [15:0] a, inout int t);
    logic [15:0] base, wa;
    base = a - (a % 16'd16);
    for (int k = 0; k < WORDS; k++) begin
      wa = base + 16'(2 * k);
      mem_q.push_back('{0, wa, 16'h0, t + 1 + k});
      cache_q.push_back('{kf, wa, mem_words[wa[15:1]], t + 1 + MEM_LAT + k});
    end
    cache_q.push_back('{kd, 16'h0, 16'h0, t + WORDS + MEM_LAT + 1});
    t = t + WORDS + MEM_LAT + 2;
  endtask

  task automatic service(int budget);
    int n;
    n = 0;
    while ((i_miss || d_miss || d_wr_req || cache_q.size() > 0 || mem_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (i_fill_done) i_miss = 1'b0;
      if (d_fill_done) d_miss = 1'b0;
      if (d_wr_ack)    d_wr_req = 1'b0;
    end
    if (i_miss || d_miss || d_wr_req || cache_q.size() > 0 || mem_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL timeout: requests/expectations still pending after %0d cycles, expected none", budget);
      mon_on = 1'b0;
      rst = 1'b1;
      i_miss = 1'b0;
      d_miss = 1'b0;
      d_wr_req = 1'b0;
      repeat (MEM_LAT + 3) @(negedge clk);
      cache_q.delete();
      mem_q.delete();
      rst = 1'b0;
      mon_on = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(bit w, logic [15:0] wa, logic [15:0] wd,
                       bit dm, logic [15:0] da, bit im, logic [15:0] ia);
    int t;
    t = cyc;
    d_wr_addr = wa;
    d_wr_data = wd;
    d_miss_addr = da;
    i_miss_addr = ia;
    d_wr_req = w;
    d_miss = dm;
    i_miss = im;
    if (w) begin
      mem_q.push_back('{1, wa, wd, t + 1});
      cache_q.push_back('{K_ACK, 16'h0, 16'h0, t + MEM_LAT});
      t = t + MEM_LAT + 1;
    end
    if (dm) model_fill(K_FILL_D, K_DONE_D, da, t);
    if (im) model_fill(K_FILL_I, K_DONE_I, ia, t);
    service(200);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_ctl"}, {57'h0, mem_en, mem_wr, fill_i_we, fill_d_we, i_fill_done, d_fill_done, d_wr_ack}, 64'h0);
    chk({nm, "_bus"}, {mem_addr, mem_wdata, fill_addr, fill_data}, 64'h0);
  endtask

  initial begin : stim
    int t0;
    bit w, dm, im;
    for (int i = 0; i < 32768; i++) mem_words[i] = 16'($urandom);
    for (int k = 0; k < WORDS; k++) mem_words[32 + k] = 16'h1000 + 16'(k);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    // lone I miss inside block 0x0040
    issue(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0046);
    // I and D miss together: D first
    issue(1'b0, 16'h0, 16'h0, 1'b1, 16'h2010, 1'b1, 16'($urandom));
    // store together with a D miss
    issue(1'b1, 16'h3002, 16'hBEEF, 1'b1, 16'($urandom), 1'b0, 16'h0);
    // top-of-memory block
    issue(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFC, 1'b0, 16'h0);

    // reset at the third returned word of an I fill
    t0 = cyc;
    i_miss_addr = 16'h5A26;
    i_miss = 1'b1;
    for (int k = 0; k < 7; k++) mem_q.push_back('{0, 16'h5A20 + 16'(2 * k), 16'h0, t0 + 1 + k});
    for (int k = 0; k < 3; k++)
      cache_q.push_back('{K_FILL_I, 16'h5A20 + 16'(2 * k), mem_words[(16'h5A20 >> 1) + k], t0 + 1 + MEM_LAT + k});
    while (cyc < t0 + 7) @(negedge clk);
    rst = 1'b1;
    i_miss = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_abort");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("reset_abort_drained", 64'(cache_q.size() + mem_q.size()), 64'h0);

    // stray rvalid while idle must be ignored
    inj = 1'b1;
    repeat (3) @(negedge clk);
    inj = 1'b0;
    repeat (2) @(negedge clk);
    issue(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'($urandom));

    for (int s = 0; s < 25; s++) begin
      w  = 1'($urandom_range(0, 1));
      dm = 1'($urandom_range(0, 1));
      im = 1'($urandom_range(0, 1));
      if (!w && !dm && !im) im = 1'b1;
      issue(w, 16'($urandom), 16'($urandom), dm, 16'($urandom), im, 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("final_cache_q_empty", 64'(cache_q.size()), 64'h0);
    chk("final_mem_q_empty", 64'(mem_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the I-cache and D-cache between the pipeline caches and the single multicycle main memory. It sequences 8-word block fills on cache misses and write-through stores, and returns filled words to the requesting cache's data/tag arrays. It sits directly below the caches that stall the pipeline on `IF_stall`/`MEM_stall`. The caches hold their miss lines high until this block pulses the matching done/ack output.

## Interface
Parameters:
- `ADDR_W`, 16, byte-address width.
- `WORDS`, 8, 16-bit words per cache block (16-byte blocks).
- `MEM_LAT`, 4, memory read/write latency in cycles.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_miss`  in  1  I-cache fill request (level, held until `i_fill_done`).
- `i_miss_addr`  in  16  I-cache miss byte address.
- `d_miss`  in  1  D-cache fill request (level, held until `d_fill_done`).
- `d_miss_addr`  in  16  D-cache miss byte address.
- `d_wr_req`  in  1  write-through store request (level, held until `d_wr_ack`).
- `d_wr_addr`  in  16  store byte address.
- `d_wr_data`  in  16  store data.
- `mem_en`  out  1  memory access strobe.
- `mem_wr`  out  1  1 = write, 0 = read (valid with `mem_en`).
- `mem_addr`  out  16  memory byte address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data.
- `mem_rvalid`  in  1  `mem_rdata` valid, `MEM_LAT` cycles after the read strobe.
- `fill_i_we`  out  1  write `fill_data` into the I-cache data array.
- `fill_d_we`  out  1  write `fill_data` into the D-cache data array.
- `fill_addr`  out  16  byte address of the word being filled.
- `fill_data`  out  16  filled word.
- `i_fill_done`  out  1  one-cycle pulse: I block complete, write tag/valid.
- `d_fill_done`  out  1  one-cycle pulse: D block complete, write tag/valid.
- `d_wr_ack`  out  1  one-cycle pulse: store retired to memory.

## Operation
- States: IDLE, WRITE, FILL, DONE.
- Arbitration in IDLE uses fixed priority: `d_wr_req` > `d_miss` > `i_miss`. The grant target (I or D) is latched at state entry and is not re-arbitrated mid-operation.
- IDLE -> WRITE: latch address and data.
  - `mem_en=1`, `mem_wr=1` in the first WRITE cycle only.
  - WRITE lasts `MEM_LAT` cycles; `d_wr_ack` pulses in the last WRITE cycle, then the block returns to IDLE.
- IDLE -> FILL: base = miss_addr & 16'hFFF0.
  - An issue counter `ic` (0..WORDS-1) drives `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*ic` on each FILL cycle until all 8 reads are issued.
  - A return counter `rc` increments on each `mem_rvalid`. Each returned word drives `fill_*_we` (target only), `fill_addr = base + 2*rc`, and `fill_data = mem_rdata` in the same cycle (combinational pass-through).
  - On the 8th return the block goes to DONE.
- DONE: one cycle. Pulse the target's `*_fill_done`, then go to IDLE. A request still pending is arbitrated in the next IDLE cycle.
- `mem_rvalid` outside FILL is ignored.
- Address wrap: `base + 2*ic` wraps modulo 2^16; base 16'hFFF0 fills FFF0..FFFE.
- Simultaneous `i_miss` and `d_miss`: D is filled first. I stays held and is served after D's DONE plus one IDLE cycle.
- Reset mid-operation: state returns to IDLE and counters clear. In-flight memory returns are discarded, and no done/ack is issued for the aborted request.
- Reset values: every output is 0 (`mem_addr`, `mem_wdata`, `fill_addr`, `fill_data` = 16'h0000).

## Timing
- Request sampled in IDLE at cycle T; the state change is visible at T+1.
- Fill:
  - Reads issued T+1..T+8.
  - Data returns T+1+MEM_LAT .. T+8+MEM_LAT, i.e. T+5..T+12 at default.
  - `*_fill_done` at T+13.
  - IDLE at T+14.
  - Total miss service is 13 cycles plus 1 cycle of arbitration gap.
- Write: strobe at T+1, `d_wr_ack` at T+MEM_LAT (T+4), IDLE at T+5.
- At most one request is in service. Requests must stay stable while pending; a request dropped early is a protocol violation, flagged by an assertion.

## Structure
- Package `cache_mem_pkg`:
  - state enum {IDLE, WRITE, FILL, DONE}
  - constants `BLOCK_MASK = 16'hFFF0`, `WORD_BYTES = 2`
  - target encoding {TGT_I, TGT_D}
- One natural sub-module: `fill_word_counter`, a 3-bit counter with clear, enable and terminal flag, instantiated twice (issue and return).

## Test plan
- I miss alone, `i_miss_addr=16'h0046`, memory returns words 0x1000+k -> reads at 0x0040..0x004E on T+1..T+8; `fill_i_we` with data 0x1000..0x1007 on T+5..T+12; `i_fill_done` at T+13; `fill_d_we` never asserts.
- `i_miss` and `d_miss` (0x2010) rise the same cycle -> D block filled first (`d_fill_done` at T+13); I fill issues from T+15; `i_fill_done` at T+27.
- `d_wr_req` (0x3002, 0xBEEF) together with `d_miss` -> one strobe with `mem_wr=1`, addr 0x3002, data 0xBEEF; `d_wr_ack` at T+4; D fill starts at T+6.
- Miss at 0xFFFC -> addresses 0xFFF0..0xFFFE, no carry beyond 16 bits.
- `rst` asserted at the 3rd return of an I fill -> all outputs 0 next cycle; remaining `mem_rvalid` produce no `fill_i_we`; no `i_fill_done`.
- `mem_rvalid` pulsed while in IDLE -> no fill writes, state stays IDLE.
